// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types for the elevator controller
// Contents: FLOOR_W (floor index width), floor_t, state_t (controller FSM states).
package elevator_pkg;

  localparam int FLOOR_W = 2;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

endpackage

// File: rtl/elevator_req_fifo.sv
// rtl/elevator_req_fifo.sv - floor request queue with duplicate suppression
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_valid_i      push strobe; ignored when full or when the floor is already queued
//   push_data_i       floor to enqueue
//   pop_i             remove head; ignored when empty
//   head_o            floor at the head, 0 when empty
//   count_o           number of queued entries
//   full_o, empty_o   queue status
module elevator_req_fifo
  import elevator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid_i,
  input  floor_t                   push_data_i,
  input  logic                     pop_i,
  output floor_t                   head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  floor_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  logic            dup;
  logic [PW-1:0]   idx;
  logic            push_en;
  logic            pop_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Duplicate search walks the occupied slots starting at the head, so it
  // sees the contents before any pop in the same cycle.
  always_comb begin
    dup = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (mem_q[idx] == push_data_i)) begin
        dup = 1'b1;
      end
    end
  end

  assign push_en = push_valid_i && !full_o && !dup;
  assign pop_en  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// rtl/elevator_controller.sv - elevator sequencing FSM with request queue and travel timer
// Optional feature macro: EMERG_STOP_EN (adds input emergStop).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   emergStop      (EMERG_STOP_EN only) freezes motion and holds IDLE while high
//   reqValid       floor request strobe
//   reqFloor       requested floor
//   reqReady       queue can accept a request
//   actualFloor    current floor
//   pos0Mem        head of the request queue (0 when empty)
//   motorUp        motor drive up
//   motorDown      motor drive down
//   doorOpen       door open command
//   queueCount     queued entries
//   arrivePulse    high in the first DOOR_OPEN cycle
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int QUEUE_DEPTH   = 4,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef EMERG_STOP_EN
  input  logic                          emergStop,
`endif
  input  logic                          reqValid,
  input  logic [FLOOR_W-1:0]            reqFloor,
  output logic                          reqReady,
  output logic [FLOOR_W-1:0]            actualFloor,
  output logic [FLOOR_W-1:0]            pos0Mem,
  output logic                          motorUp,
  output logic                          motorDown,
  output logic                          doorOpen,
  output logic [$clog2(QUEUE_DEPTH):0]  queueCount,
  output logic                          arrivePulse
);

  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

  state_t         state_q, state_d;
  logic [TW-1:0]  travel_q, travel_d;
  logic [DW-1:0]  door_q, door_d;
  floor_t         floor_q, floor_d;

  logic           pop;
  logic           q_full;
  logic           q_empty;
  floor_t         head;
  logic           stop;
  logic           up;
  logic           emerg;

`ifdef EMERG_STOP_EN
  assign emerg = emergStop;
`else
  assign emerg = 1'b0;
`endif

  elevator_req_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (reqValid),
    .push_data_i  (reqFloor),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (queueCount),
    .full_o       (q_full),
    .empty_o      (q_empty)
  );

  assign reqReady    = !q_full;
  assign pos0Mem     = head;
  assign actualFloor = floor_q;

  // Comparator terms use registered head and floor only.
  assign stop = (head == floor_q);
  assign up   = (head > floor_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      travel_q <= '0;
      door_q   <= '0;
      floor_q  <= '0;
    end else begin
      state_q  <= state_d;
      travel_q <= travel_d;
      door_q   <= door_d;
      floor_q  <= floor_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    travel_d    = travel_q;
    door_d      = door_q;
    floor_d     = floor_q;
    pop         = 1'b0;
    motorUp     = 1'b0;
    motorDown   = 1'b0;
    doorOpen    = 1'b0;
    arrivePulse = 1'b0;

    case (state_q)
      IDLE: begin
        travel_d = '0;
        if (!q_empty && !emerg) begin
          if (stop) begin
            pop     = 1'b1;
            state_d = DOOR_OPEN;
          end else if (up) begin
            state_d = MOVE_UP;
          end else begin
            state_d = MOVE_DOWN;
          end
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        motorUp   = (state_q == MOVE_UP) && !emerg;
        motorDown = (state_q == MOVE_DOWN) && !emerg;
        // Emergency stop freezes the counter so release resumes mid-floor.
        if (!emerg) begin
          if (travel_q == TRAVEL_LAST) begin
            travel_d = '0;
            floor_d  = (state_q == MOVE_UP) ? floor_q + floor_t'(1)
                                            : floor_q - floor_t'(1);
            if (floor_d == head) begin
              pop     = 1'b1;
              state_d = DOOR_OPEN;
            end
          end else begin
            travel_d = travel_q + TW'(1);
          end
        end
      end

      DOOR_OPEN: begin
        doorOpen    = 1'b1;
        arrivePulse = (door_q == '0);
        if (door_q == DOOR_LAST) begin
          door_d  = '0;
          state_d = IDLE;
        end else begin
          door_d = door_q + DW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_elevator_controller.sv
// tb/tb_elevator_controller.sv - directed self-checking bench for elevator_controller
module tb_elevator_controller;
  import elevator_pkg::*;

  localparam int TC = 4;
  localparam int DC = 3;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        emergStop;
  logic        reqValid;
  logic [1:0]  reqFloor;
  logic        reqReady;
  logic [1:0]  actualFloor;
  logic [1:0]  pos0Mem;
  logic        motorUp;
  logic        motorDown;
  logic        doorOpen;
  logic [2:0]  queueCount;
  logic        arrivePulse;

  int checks = 0;
  int errors = 0;

  int w_up, w_dn, w_door, w_arr, w_bad, w_door_at, w_arr_at_door, w_head_at_door;
  int w_frz_mot, w_frz_fl;
  int w_fl [4];

  elevator_controller #(
    .QUEUE_DEPTH   (QD),
    .TRAVEL_CYCLES (TC),
    .DOOR_CYCLES   (DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef EMERG_STOP_EN
    .emergStop   (emergStop),
`endif
    .reqValid    (reqValid),
    .reqFloor    (reqFloor),
    .reqReady    (reqReady),
    .actualFloor (actualFloor),
    .pos0Mem     (pos0Mem),
    .motorUp     (motorUp),
    .motorDown   (motorDown),
    .doorOpen    (doorOpen),
    .queueCount  (queueCount),
    .arrivePulse (arrivePulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] f);
    reqValid = 1'b1;
    reqFloor = f;
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  // Samples n cycles starting at the current negedge, gathering activity stats.
  task automatic watch(input int n, input int e_on, input int e_off);
    logic [1:0] f0;
    w_up = 0; w_dn = 0; w_door = 0; w_arr = 0; w_bad = 0;
    w_door_at = -1; w_arr_at_door = 0; w_head_at_door = -1;
    w_frz_mot = 0; w_frz_fl = 0;
    f0 = actualFloor;
    for (int k = 0; k < 4; k++) w_fl[k] = -1;
    for (int i = 0; i < n; i++) begin
      if (i == e_on)  emergStop = 1'b1;
      if (i == e_off) emergStop = 1'b0;
      #1;
      if (i == e_on) f0 = actualFloor;
      if (motorUp)     w_up++;
      if (motorDown)   w_dn++;
      if (doorOpen)    w_door++;
      if (arrivePulse) w_arr++;
      if ((motorUp && motorDown) || ((motorUp || motorDown) && doorOpen)) w_bad++;
      if (doorOpen && w_door_at < 0) begin
        w_door_at      = i;
        w_arr_at_door  = int'(arrivePulse);
        w_head_at_door = int'(pos0Mem);
      end
      if (w_fl[actualFloor] < 0) w_fl[actualFloor] = i;
      if (emergStop) begin
        if (motorUp || motorDown) w_frz_mot++;
        if (actualFloor != f0)    w_frz_fl++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n     = 1'b0;
    reqValid  = 1'b0;
    reqFloor  = 2'd0;
    emergStop = 1'b0;
    cyc(2);
    #1;
    chk("rst_floor",   actualFloor, 0);
    chk("rst_head",    pos0Mem, 0);
    chk("rst_motor",   {motorUp, motorDown}, 0);
    chk("rst_door",    doorOpen, 0);
    chk("rst_count",   queueCount, 0);
    chk("rst_ready",   reqReady, 1);
    chk("rst_arrive",  arrivePulse, 0);
    rst_n = 1'b1;
    cyc(1);

    // 1: request for the current floor opens the door without moving
    push(2'd0);
    #1;
    chk("t1_count_after_push", queueCount, 1);
    watch(8, -1, -1);
    chk("t1_door_at",   w_door_at, 1);
    chk("t1_arr_first", w_arr_at_door, 1);
    chk("t1_arr_n",     w_arr, 1);
    chk("t1_door_n",    w_door, DC);
    chk("t1_motor_n",   w_up + w_dn, 0);
    chk("t1_count_end", queueCount, 0);

    // 2: 0 -> 3, one floor every TC cycles
    push(2'd3);
    watch(18, -1, -1);
    chk("t2_up_n",    w_up, 3 * TC);
    chk("t2_dn_n",    w_dn, 0);
    chk("t2_fl1_at",  w_fl[1], 5);
    chk("t2_fl2_at",  w_fl[2], 9);
    chk("t2_fl3_at",  w_fl[3], 13);
    chk("t2_door_at", w_door_at, 13);
    chk("t2_arr",     w_arr_at_door, 1);
    chk("t2_head_at_door", w_head_at_door, 0);
    chk("t2_bad",     w_bad, 0);
    chk("t2_floor",   actualFloor, 3);
    chk("t2_count",   queueCount, 0);

    // 3: from 3 serve 1 (head) first, then 2
    push(2'd1);
    push(2'd2);
    watch(22, -1, -1);
    chk("t3_dn_n",     w_dn, 2 * TC);
    chk("t3_up_n",     w_up, TC);
    chk("t3_fl2_at",   w_fl[2], 4);
    chk("t3_fl1_at",   w_fl[1], 8);
    chk("t3_door_at",  w_door_at, 8);
    chk("t3_head_at_door", w_head_at_door, 2);
    chk("t3_door_n",   w_door, 2 * DC);
    chk("t3_arr_n",    w_arr, 2);
    chk("t3_bad",      w_bad, 0);
    chk("t3_floor",    actualFloor, 2);
    chk("t3_count",    queueCount, 0);

    // 7: push coinciding with pop (count unchanged), then push of the popped floor (dropped)
    push(2'd3);
    cyc(4);
    #1;
    chk("t7_moving_up", motorUp, 1);
    chk("t7_floor_pre", actualFloor, 2);
    push(2'd0);
    #1;
    chk("t7_pushpop_count", queueCount, 1);
    chk("t7_pushpop_head",  pos0Mem, 0);
    chk("t7_arrive",        arrivePulse, 1);
    chk("t7_floor3",        actualFloor, 3);
    cyc(15);
    #1;
    chk("t7_moving_down", motorDown, 1);
    chk("t7_floor1",      actualFloor, 1);
    push(2'd0);
    #1;
    chk("t7_dup_popped_count", queueCount, 0);
    chk("t7_door_at0",         doorOpen, 1);
    chk("t7_floor0",           actualFloor, 0);
    cyc(4);
    #1;
    chk("t7_idle_door", doorOpen, 0);

    // 4: fill the queue while the first trip is in progress
    push(2'd1);
    push(2'd2);
    push(2'd3);
    push(2'd0);
    #1;
    chk("t4_full_count", queueCount, 4);
    chk("t4_full_ready", reqReady, 0);
    chk("t4_full_head",  pos0Mem, 1);
    push(2'd2);
    #1;
    chk("t4_fifth_count", queueCount, 4);
    chk("t4_fifth_motor", motorUp, 1);
    cyc(1);
    #1;
    chk("t4_pop_count", queueCount, 3);
    chk("t4_pop_ready", reqReady, 1);
    chk("t4_pop_head",  pos0Mem, 2);
    chk("t4_pop_floor", actualFloor, 1);
    push(2'd2);
    #1;
    chk("t4_dup_count", queueCount, 3);

    // 5: asynchronous reset in the middle of MOVE_UP
    k = 0;
    while (!motorUp && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("t5_reach_move", motorUp, 1);
    cyc(1);
    rst_n = 1'b0;
    #1;
    chk("t5_motor", {motorUp, motorDown}, 0);
    chk("t5_door",  doorOpen, 0);
    chk("t5_floor", actualFloor, 0);
    chk("t5_count", queueCount, 0);
    chk("t5_head",  pos0Mem, 0);
    chk("t5_ready", reqReady, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

`ifdef EMERG_STOP_EN
    // 6: 5-cycle emergency stop mid-travel delays arrival by 5 cycles
    push(2'd2);
    watch(20, 3, 8);
    chk("t6_frz_motor", w_frz_mot, 0);
    chk("t6_frz_floor", w_frz_fl, 0);
    chk("t6_up_n",      w_up, 2 * TC);
    chk("t6_fl1_at",    w_fl[1], 10);
    chk("t6_door_at",   w_door_at, 14);
    chk("t6_bad",       w_bad, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
